// File: rtl/vx_perf_pkg.sv
// Shared defaults, types and channel names for the per-core performance event counters.
package vx_perf_pkg;

   localparam int unsigned PERF_NUM_EVENTS = 8;
   localparam int unsigned PERF_INC_BITS   = 3;
   localparam int unsigned PERF_CTR_BITS   = 44;

   typedef logic [PERF_CTR_BITS-1:0] perf_ctr_t;

   // FPU/GPU channels are appended after ALU_STALLS
   typedef enum logic [5:0] {
      LOADS      = 6'd0,
      STORES     = 6'd1,
      BRANCHES   = 6'd2,
      IBF_STALLS = 6'd3,
      SCB_STALLS = 6'd4,
      LSU_STALLS = 6'd5,
      CSR_STALLS = 6'd6,
      ALU_STALLS = 6'd7
   } perf_event_e;

   function automatic int unsigned perf_sel_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_perf_counter.sv
// One event channel: registered increment, accumulator, sticky overflow and snapshot shadow.
// PERF_CTR_SATURATE_EN selects saturating counters instead of wrapping ones.
module vx_perf_counter
   import vx_perf_pkg::*;
#(
   parameter int unsigned CTR_BITS = PERF_CTR_BITS,
   parameter int unsigned INC_BITS = PERF_INC_BITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [INC_BITS-1:0] inc,
   input  logic                clear,
   input  logic                snapshot,
   output logic [CTR_BITS-1:0] shadow,
   output logic                shadow_ovf
);

   logic [INC_BITS-1:0] inc_q;
   logic [CTR_BITS-1:0] ctr_q, ctr_d;
   logic                ovf_q;
   logic [CTR_BITS:0]   sum;

   assign sum = {1'b0, ctr_q} + {{(CTR_BITS + 1 - INC_BITS){1'b0}}, inc_q};

   always_comb begin
`ifdef PERF_CTR_SATURATE_EN
      ctr_d = sum[CTR_BITS] ? {CTR_BITS{1'b1}} : sum[CTR_BITS-1:0];
`else
      ctr_d = sum[CTR_BITS-1:0];
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inc_q <= '0;
         ctr_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear) begin
         inc_q <= '0;
         ctr_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         inc_q <= enable ? inc : '0;
         ctr_q <= ctr_d;
         ovf_q <= ovf_q | sum[CTR_BITS];
      end
   end

   // Shadow takes pre-update values, so snapshot+clear acts as read-and-clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow     <= '0;
         shadow_ovf <= 1'b0;
      end else if (snapshot) begin
         shadow     <= ctr_q;
         shadow_ovf <= ovf_q;
      end
   end

endmodule

// File: rtl/vx_perf_event_counters.sv
// Per-core performance event accumulator: NUM_EVENTS channels plus a shadow read port.
// Counters wrap by default; define PERF_CTR_SATURATE_EN for saturating counters.
module vx_perf_event_counters
   import vx_perf_pkg::*;
#(
   parameter int unsigned NUM_EVENTS = PERF_NUM_EVENTS,
   parameter int unsigned CTR_BITS   = PERF_CTR_BITS,
   parameter int unsigned INC_BITS   = PERF_INC_BITS,
   parameter int unsigned SEL_BITS   = perf_sel_bits(NUM_EVENTS)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           enable,
   input  logic [NUM_EVENTS*INC_BITS-1:0] event_inc,
   input  logic                           clear,
   input  logic                           snapshot,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [SEL_BITS-1:0]            req_sel,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [CTR_BITS-1:0]            rsp_data,
   output logic                           rsp_ovf
);

   logic [CTR_BITS-1:0]   shadow [NUM_EVENTS];
   logic [NUM_EVENTS-1:0] shadow_ovf;
   logic [CTR_BITS-1:0]   sel_data;
   logic                  sel_ovf;
   logic                  accept;

   for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_chan
      vx_perf_counter #(
         .CTR_BITS (CTR_BITS),
         .INC_BITS (INC_BITS)
      ) u_counter (
         .clk        (clk),
         .reset_n    (reset_n),
         .enable     (enable),
         .inc        (event_inc[i*INC_BITS +: INC_BITS]),
         .clear      (clear),
         .snapshot   (snapshot),
         .shadow     (shadow[i]),
         .shadow_ovf (shadow_ovf[i])
      );
   end

   // Out-of-range selects fall through to zero
   always_comb begin
      sel_data = '0;
      sel_ovf  = 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
         if (int'(req_sel) == i) begin
            sel_data = shadow[i];
            sel_ovf  = shadow_ovf[i];
         end
      end
   end

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_ovf   <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_data  <= sel_data;
         rsp_ovf   <= sel_ovf;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: doc/vx_perf_event_counters.md
# vx_perf_event_counters

Parametrised per-core performance event accumulator, successor to the fixed load/store/branch/stall counter bundle. Accepts `NUM_EVENTS` multi-bit increment channels from decode/issue, accumulates them into `CTR_BITS` counters through one registered input stage, and supports atomic snapshot, read-and-clear, and sticky overflow flags. Software reads counters through a valid/ready request/response port driven by the CSR unit.

## Interface
Parameters:
- `NUM_EVENTS`, 8: number of event channels (1..64).
- `CTR_BITS`, 44: counter width (matches `PERF_CTR_BITS`).
- `INC_BITS`, 3: per-channel per-cycle increment width; max increment is `2**INC_BITS-1`.
- `SEL_BITS`, `$clog2(NUM_EVENTS)` (min 1): derived, not overridden.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: sample events this cycle when high.
- `event_inc` in NUM_EVENTS*INC_BITS: channel i at bits [i*INC_BITS +: INC_BITS].
- `clear` in 1: synchronous zero of counters and overflow flags.
- `snapshot` in 1: copy live counters and flags into shadow bank.
- `req_valid` in 1 / `req_ready` out 1 / `req_sel` in SEL_BITS: read request.
- `rsp_valid` out 1 / `rsp_ready` in 1: read response handshake.
- `rsp_data` out CTR_BITS: shadow counter value.
- `rsp_ovf` out 1: shadow overflow flag.

## Operation
- Stage 1: `inc_q[i] <= enable ? event_inc[i] : 0`.
- Stage 2: `ctr[i] <= ctr[i] + zero_ext(inc_q[i])`, modulo `2**CTR_BITS` (see Configuration).
- Overflow: `ovf[i]` set when the stage-2 add carries out; sticky until clear/reset.
- `clear`: zeroes `ctr`, `ovf`, and `inc_q`; events presented in the clear cycle are dropped.
- `snapshot`: `shadow[i] <= ctr[i]`, `shadow_ovf[i] <= ovf[i]` (pre-update register values). In-flight `inc_q` is not included.
- `snapshot` and `clear` in the same cycle: shadow captures pre-clear values; live counters clear (read-and-clear).
- Read port:
  - `req_ready = !rsp_valid || rsp_ready`.
  - On accept, the one-entry response register loads `shadow[req_sel]`/`shadow_ovf[req_sel]`.
  - `req_sel >= NUM_EVENTS` returns data 0, ovf 0.
  - `rsp_valid` holds and data is stable until `rsp_ready`.
  - A snapshot while a response is pending does not alter the pending response.

## Timing
- Reset values: all `ctr`, `ovf`, `inc_q`, `shadow`, `shadow_ovf` = 0; `rsp_valid` = 0; `rsp_data` = 0; `rsp_ovf` = 0; `req_ready` = 1.
- Event-to-counter latency: an event sampled at edge N is visible in `ctr` after edge N+1. A snapshot at N+2 includes it; a snapshot at N+1 does not.
- Read latency: request accepted at edge N gives `rsp_valid` high after edge N.
- Full throughput: back-to-back requests with `rsp_ready` held high.
- `reset_n` asserted mid-operation: all state returns to reset values immediately. A pending response is lost and `rsp_valid` drops asynchronously.

## Configuration
- `PERF_CTR_SATURATE_EN` defined: counters saturate at all-ones. Overflow still sets `ovf[i]`, and `ctr[i]` stays `2**CTR_BITS-1`.
- Macro undefined: counters wrap modulo `2**CTR_BITS`. `ovf[i]` sets on carry-out.

## Structure
- Package `vx_perf_pkg`:
  - localparam defaults `PERF_NUM_EVENTS`, `PERF_INC_BITS`.
  - typedef `perf_ctr_t` (logic [CTR_BITS-1:0]).
  - enum `perf_event_e` naming channels: LOADS, STORES, BRANCHES, IBF_STALLS, SCB_STALLS, LSU_STALLS, CSR_STALLS, ALU_STALLS (FPU/GPU appended).
- Sub-module `vx_perf_counter`: one channel's `inc_q`, counter, overflow logic, and shadow. Instantiated `NUM_EVENTS` times in a generate loop. The top level holds the read mux and response register.

## Test plan
- Reset → `rsp_valid`=0, `req_ready`=1. After snapshot, reading every sel returns 0/ovf 0.
- Enable=1, channel 2 inc=3 for 10 cycles, then 2 idle cycles, snapshot, read sel 2 → `rsp_data`=30, ovf=0. Other channels read 0.
- Enable=0 with channel 0 inc=7 for 5 cycles → counter 0 after snapshot/read.
- `CTR_BITS`=8, channel 0 inc=7 for 40 cycles:
  - wrap build: 280 mod 256 = 24, ovf=1.
  - `PERF_CTR_SATURATE_EN` build: 255, ovf=1.
- Snapshot+clear same cycle with ctr[1]=17 → read sel 1 returns 17. A following snapshot+read returns 0 (plus any post-clear events).
- Response backpressure:
  - `rsp_ready`=0 for 4 cycles with a second request pending → `req_ready`=0 and `rsp_data` stable.
  - Release → second response the next cycle.
  - sel=NUM_EVENTS returns 0.
